// File: rtl/fetch_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_ctrl_pkg
// Description : Shared types for the fetch stage controller: controller
//               state encoding, held fetch-group record, instruction size.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_ctrl_pkg;

  localparam int FETCH_WIDTH_DEF = 2;
  localparam int PC_WIDTH_DEF    = 32;

  // Bytes per instruction word; slot i of a group sits at base PC + i*4.
  localparam int INSN_BYTE_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_EMPTY     = 3'd0,
    ST_VALID     = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_DRAIN     = 3'd4
  } fetch_ctrl_state_e;

  typedef struct packed {
    logic [FETCH_WIDTH_DEF-1:0] valid;
    logic [PC_WIDTH_DEF-1:0]    pc;
  } held_group_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_ctrl_miss_perf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_miss_perf_counter
// Description : Two saturating performance counters: misses started and
//               cycles spent inside the miss handling states.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_miss_perf_counter #(
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss_start,
  input  logic                      in_miss,
  output logic [PERF_CNT_WIDTH-1:0] miss_count,
  output logic [PERF_CNT_WIDTH-1:0] miss_cycles
);

  logic [PERF_CNT_WIDTH-1:0] miss_count_q,  miss_count_d;
  logic [PERF_CNT_WIDTH-1:0] miss_cycles_q, miss_cycles_d;

  // Increment each counter on its qualifier, holding at all-ones.
  always_comb begin
    miss_count_d  = miss_count_q;
    miss_cycles_d = miss_cycles_q;
    if (miss_start && !(&miss_count_q)) begin
      miss_count_d = miss_count_q + 1'b1;
    end
    if (in_miss && !(&miss_cycles_q)) begin
      miss_cycles_d = miss_cycles_q + 1'b1;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count_q  <= '0;
      miss_cycles_q <= '0;
    end else begin
      miss_count_q  <= miss_count_d;
      miss_cycles_q <= miss_cycles_d;
    end
  end

  assign miss_count  = miss_count_q;
  assign miss_cycles = miss_cycles_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_ctrl
// Description : Fetch stage controller. Holds the group issued by the next-PC
//               stage, pairs it with the I-cache result, runs the miss
//               handshake, delivers to decode and back-pressures next-PC.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage_ctrl
  import fetch_stage_ctrl_pkg::*;
#(
  parameter int FETCH_WIDTH    = 2,
  parameter int PC_WIDTH       = 32,
  parameter int INSN_WIDTH     = 32,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic [FETCH_WIDTH-1:0]            np_valid,
  input  logic [PC_WIDTH-1:0]               np_pc,
  input  logic                              ic_hit,
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0] ic_data,
  output logic                              ic_miss_req,
  output logic [PC_WIDTH-1:0]               ic_miss_addr,
  input  logic                              ic_fill_done,
  input  logic                              dec_ready,
  output logic [FETCH_WIDTH-1:0]            dec_valid,
  output logic [PC_WIDTH-1:0]               dec_pc,
  output logic [FETCH_WIDTH*INSN_WIDTH-1:0] dec_insn,
  output logic                              stall_out,
  output logic [PERF_CNT_WIDTH-1:0]         miss_count,
  output logic [PERF_CNT_WIDTH-1:0]         miss_cycles
);

  fetch_ctrl_state_e      state_q, state_d;
  logic [FETCH_WIDTH-1:0] hv_q,    hv_d;
  logic [PC_WIDTH-1:0]    hpc_q,   hpc_d;

  logic w_stall;
  logic w_miss_req;
  logic w_miss_start;
  logic w_fire;
  logic w_capture;
  logic w_in_miss;

  // Next-state, held-group update and per-state outputs; clear overrides all.
  always_comb begin
    state_d      = state_q;
    hv_d         = hv_q;
    hpc_d        = hpc_q;
    w_stall      = 1'b0;
    w_miss_req   = 1'b0;
    w_miss_start = 1'b0;
    w_fire       = 1'b0;
    w_capture    = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        w_capture = 1'b1;
      end
      ST_VALID: begin
        if (ic_hit && dec_ready) begin
          w_fire    = 1'b1;
          w_capture = 1'b1;
        end else if (ic_hit) begin
          w_stall = 1'b1;
        end else begin
          w_stall      = 1'b1;
          w_miss_start = 1'b1;
          state_d      = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        w_stall    = 1'b1;
        w_miss_req = 1'b1;
        state_d    = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        w_stall = 1'b1;
        if (ic_fill_done) begin
          state_d = ST_VALID;
        end
      end
      ST_DRAIN: begin
        w_stall = 1'b1;
        if (ic_fill_done) begin
          state_d = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // An all-invalid group is loaded but never treated as held.
    if (w_capture) begin
      hv_d    = np_valid;
      hpc_d   = np_pc;
      state_d = (|np_valid) ? ST_VALID : ST_EMPTY;
    end

    // A flush with a fill still outstanding must wait it out in DRAIN.
    if (clear) begin
      hv_d         = '0;
      hpc_d        = hpc_q;
      w_fire       = 1'b0;
      w_miss_req   = 1'b0;
      w_miss_start = 1'b0;
      if (((state_q == ST_MISS_WAIT) || (state_q == ST_DRAIN)) && !ic_fill_done) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // State and held-group registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      hv_q    <= '0;
      hpc_q   <= '0;
    end else begin
      state_q <= state_d;
      hv_q    <= hv_d;
      hpc_q   <= hpc_d;
    end
  end

  assign w_in_miss = (state_q == ST_MISS_REQ) || (state_q == ST_MISS_WAIT) ||
                     (state_q == ST_DRAIN);

  assign ic_miss_req  = w_miss_req;
  assign ic_miss_addr = hpc_q;
  assign dec_valid    = w_fire ? hv_q : '0;
  assign dec_pc       = hpc_q;
  assign dec_insn     = ic_data;
  assign stall_out    = w_stall;

  fetch_miss_perf_counter #(
    .PERF_CNT_WIDTH (PERF_CNT_WIDTH)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .miss_start  (w_miss_start),
    .in_miss     (w_in_miss),
    .miss_count  (miss_count),
    .miss_cycles (miss_cycles)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage_ctrl
// Description : Self-checking bench for fetch_stage_ctrl: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [1:0]  np_valid;
  logic [31:0] np_pc;
  logic        ic_hit;
  logic [63:0] ic_data;
  logic        ic_miss_req;
  logic [31:0] ic_miss_addr;
  logic        ic_fill_done;
  logic        dec_ready;
  logic [1:0]  dec_valid;
  logic [31:0] dec_pc;
  logic [63:0] dec_insn;
  logic        stall_out;
  logic [31:0] miss_count;
  logic [31:0] miss_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .np_valid     (np_valid),
    .np_pc        (np_pc),
    .ic_hit       (ic_hit),
    .ic_data      (ic_data),
    .ic_miss_req  (ic_miss_req),
    .ic_miss_addr (ic_miss_addr),
    .ic_fill_done (ic_fill_done),
    .dec_ready    (dec_ready),
    .dec_valid    (dec_valid),
    .dec_pc       (dec_pc),
    .dec_insn     (dec_insn),
    .stall_out    (stall_out),
    .miss_count   (miss_count),
    .miss_cycles  (miss_cycles)
  );

  // Behavioural model: "has a group" flag plus a miss phase
  // (0 none, 1 request due, 2 waiting for fill, 3 draining a flushed fill).
  logic        m_has;
  logic [1:0]  m_hv;
  logic [31:0] m_hpc;
  int          m_phase;
  logic [31:0] m_mc;
  logic [31:0] m_mcy;
  logic        m_in_miss;
  logic        m_stall;

  // Advance the model on each clock from the inputs alone.
  always @(posedge clk) begin
    if (rst) begin
      m_has = 1'b0; m_hv = 2'b00; m_hpc = 32'h0; m_phase = 0; m_mc = 32'h0; m_mcy = 32'h0;
    end else begin
      m_in_miss = (m_phase != 0);
      m_stall   = m_in_miss || (m_has && !(ic_hit && dec_ready));
      if (m_in_miss && (m_mcy != 32'hFFFF_FFFF)) m_mcy = m_mcy + 1;
      if (clear) begin
        m_has   = 1'b0;
        m_hv    = 2'b00;
        m_phase = (((m_phase == 2) || (m_phase == 3)) && !ic_fill_done) ? 3 : 0;
      end else if (!m_stall) begin
        m_has = |np_valid;
        m_hv  = np_valid;
        m_hpc = np_pc;
      end else if ((m_phase == 0) && !ic_hit) begin
        m_phase = 1;
        if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if ((m_phase >= 2) && ic_fill_done) begin
        m_phase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; np_valid = 2'b00; np_pc = 32'h0; ic_hit = 1'b0;
    ic_fill_done = 1'b0; dec_ready = 1'b0;
    ic_data = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (ic_miss_req !== 1'b0) begin errors++; $display("FAIL reset_miss_req got=%0b exp=0", ic_miss_req); end
    checks++; if (ic_miss_addr !== 32'h0) begin errors++; $display("FAIL reset_miss_addr got=%h exp=0", ic_miss_addr); end
    checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL reset_dec_valid got=%b exp=00", dec_valid); end
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got=%h exp=0", dec_pc); end
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_out); end
    checks++; if (miss_count !== 32'h0 || miss_cycles !== 32'h0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", miss_count, miss_cycles); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    np_valid = 2'b11; np_pc = 32'h1000; ic_hit = 1'b1; dec_ready = 1'b1;
    tick();
    np_pc = 32'h1008;
    @(negedge clk);
    checks++; if (dec_valid !== 2'b11 || dec_pc !== 32'h1000 || stall_out !== 1'b0) begin errors++; $display("FAIL b2b_first got=%b/%h/%b exp=11/1000/0", dec_valid, dec_pc, stall_out); end
    checks++; if (dec_insn !== ic_data) begin errors++; $display("FAIL b2b_insn got=%h exp=%h", dec_insn, ic_data); end
    tick();
    np_valid = 2'b00;
    @(negedge clk);
    checks++; if (dec_valid !== 2'b11 || dec_pc !== 32'h1008) begin errors++; $display("FAIL b2b_second got=%b/%h exp=11/1008", dec_valid, dec_pc); end
    tick();
    @(negedge clk);
    checks++; if (dec_valid !== 2'b00 || stall_out !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b/%b exp=00/0", dec_valid, stall_out); end
    idle_inputs();
  endtask

  task automatic test_miss();
    rst = 1'b1; tick(); rst = 1'b0;
    np_valid = 2'b11; np_pc = 32'h2000; ic_hit = 1'b0; dec_ready = 1'b1;
    tick();
    np_valid = 2'b00;
    @(negedge clk);
    checks++; if (stall_out !== 1'b1 || dec_valid !== 2'b00 || ic_miss_req !== 1'b0) begin errors++; $display("FAIL miss_detect got=%b/%b/%b exp=1/00/0", stall_out, dec_valid, ic_miss_req); end
    tick();
    @(negedge clk);
    checks++; if (ic_miss_req !== 1'b1 || ic_miss_addr !== 32'h2000) begin errors++; $display("FAIL miss_req got=%b/%h exp=1/2000", ic_miss_req, ic_miss_addr); end
    for (int k = 0; k < 6; k++) begin
      tick();
      ic_fill_done = (k == 5);
      @(negedge clk);
      checks++; if (ic_miss_req !== 1'b0 || stall_out !== 1'b1) begin errors++; $display("FAIL miss_wait%0d got=%b/%b exp=0/1", k, ic_miss_req, stall_out); end
    end
    tick();
    ic_fill_done = 1'b0; ic_hit = 1'b1;
    @(negedge clk);
    checks++; if (dec_valid !== 2'b11 || dec_pc !== 32'h2000) begin errors++; $display("FAIL miss_deliver got=%b/%h exp=11/2000", dec_valid, dec_pc); end
    tick();
    @(negedge clk);
    checks++; if (miss_count !== 32'd1 || miss_cycles !== 32'd7) begin errors++; $display("FAIL miss_counters got=%0d/%0d exp=1/7", miss_count, miss_cycles); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    np_valid = 2'b11; np_pc = 32'h3000; ic_hit = 1'b1; dec_ready = 1'b0;
    tick();
    np_valid = 2'b10; np_pc = 32'h9990;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (dec_valid !== 2'b00 || stall_out !== 1'b1 || dec_pc !== 32'h3000) begin errors++; $display("FAIL bp_hold%0d got=%b/%b/%h exp=00/1/3000", k, dec_valid, stall_out, dec_pc); end
      tick();
    end
    dec_ready = 1'b1; np_valid = 2'b00;
    @(negedge clk);
    checks++; if (dec_valid !== 2'b11 || dec_pc !== 32'h3000) begin errors++; $display("FAIL bp_release got=%b/%h exp=11/3000", dec_valid, dec_pc); end
    tick();
    @(negedge clk);
    checks++; if (dec_valid !== 2'b00) begin errors++; $display("FAIL bp_once got=%b exp=00", dec_valid); end
    idle_inputs();
  endtask

  task automatic test_clear_drain();
    np_valid = 2'b11; np_pc = 32'h4000; ic_hit = 1'b0; dec_ready = 1'b1;
    tick();
    np_valid = 2'b00;
    tick();
    tick();
    clear = 1'b1;
    @(negedge clk);
    checks++; if (dec_valid !== 2'b00 || stall_out !== 1'b1) begin errors++; $display("FAIL drain_clear got=%b/%b exp=00/1", dec_valid, stall_out); end
    tick();
    clear = 1'b0; ic_hit = 1'b1;
    @(negedge clk);
    checks++; if (stall_out !== 1'b1 || dec_valid !== 2'b00 || ic_miss_req !== 1'b0) begin errors++; $display("FAIL drain_state got=%b/%b/%b exp=1/00/0", stall_out, dec_valid, ic_miss_req); end
    tick();
    ic_fill_done = 1'b1;
    @(negedge clk);
    checks++; if (stall_out !== 1'b1 || dec_valid !== 2'b00) begin errors++; $display("FAIL drain_fill got=%b/%b exp=1/00", stall_out, dec_valid); end
    tick();
    ic_fill_done = 1'b0; np_valid = 2'b11; np_pc = 32'h5000;
    @(negedge clk);
    checks++; if (stall_out !== 1'b0 || dec_valid !== 2'b00) begin errors++; $display("FAIL drain_empty got=%b/%b exp=0/00", stall_out, dec_valid); end
    tick();
    np_valid = 2'b00;
    @(negedge clk);
    checks++; if (dec_valid !== 2'b11 || dec_pc !== 32'h5000) begin errors++; $display("FAIL drain_new got=%b/%h exp=11/5000", dec_valid, dec_pc); end
    tick();
    idle_inputs();
  endtask

  task automatic test_partial();
    np_valid = 2'b01; np_pc = 32'h100C; ic_hit = 1'b1; dec_ready = 1'b1;
    tick();
    np_valid = 2'b00;
    @(negedge clk);
    checks++; if (dec_valid !== 2'b01 || dec_pc !== 32'h100C) begin errors++; $display("FAIL partial got=%b/%h exp=01/100c", dec_valid, dec_pc); end
    tick();
    idle_inputs();
  endtask

  task automatic test_clear_missreq_and_rst();
    np_valid = 2'b11; np_pc = 32'h6000; ic_hit = 1'b0; dec_ready = 1'b1;
    tick();
    np_valid = 2'b00;
    tick();
    clear = 1'b1;
    @(negedge clk);
    checks++; if (ic_miss_req !== 1'b0) begin errors++; $display("FAIL clr_req_pulse got=%b exp=0", ic_miss_req); end
    tick();
    clear = 1'b0; np_valid = 2'b11; np_pc = 32'h7000;
    @(negedge clk);
    checks++; if (stall_out !== 1'b0 || ic_miss_req !== 1'b0) begin errors++; $display("FAIL clr_req_empty got=%b/%b exp=0/0", stall_out, ic_miss_req); end
    tick();
    np_valid = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ic_miss_req !== 1'b0 || ic_miss_addr !== 32'h0 || dec_valid !== 2'b00 || dec_pc !== 32'h0 || stall_out !== 1'b0) begin errors++; $display("FAIL rst_mid_miss got=%b/%h/%b/%h/%b exp=0/0/00/0/0", ic_miss_req, ic_miss_addr, dec_valid, dec_pc, stall_out); end
    checks++; if (miss_count !== 32'h0 || miss_cycles !== 32'h0) begin errors++; $display("FAIL rst_mid_counters got=%0d/%0d exp=0/0", miss_count, miss_cycles); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [1:0] e_dv;
    logic       e_stall;
    logic       e_req;
    for (int n = 0; n < 2000; n++) begin
      clear        = ($urandom_range(0, 15) == 0);
      np_valid     = 2'($urandom);
      np_pc        = $urandom & 32'hFFFF_FFFC;
      ic_hit       = ($urandom_range(0, 3) != 0);
      dec_ready    = ($urandom_range(0, 3) != 0);
      ic_fill_done = ($urandom_range(0, 3) == 0);
      ic_data      = {$urandom, $urandom};
      @(negedge clk);
      e_stall = (m_phase != 0) || (m_has && !(ic_hit && dec_ready));
      e_req   = (m_phase == 1) && !clear;
      e_dv    = ((m_phase == 0) && m_has && ic_hit && dec_ready && !clear) ? m_hv : 2'b00;
      checks++; if (dec_valid !== e_dv) begin errors++; $display("FAIL rnd_dec_valid n=%0d got=%b exp=%b", n, dec_valid, e_dv); end
      checks++; if (dec_pc !== m_hpc) begin errors++; $display("FAIL rnd_dec_pc n=%0d got=%h exp=%h", n, dec_pc, m_hpc); end
      checks++; if (dec_insn !== ic_data) begin errors++; $display("FAIL rnd_dec_insn n=%0d got=%h exp=%h", n, dec_insn, ic_data); end
      checks++; if (stall_out !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_out, e_stall); end
      checks++; if (ic_miss_req !== e_req) begin errors++; $display("FAIL rnd_miss_req n=%0d got=%b exp=%b", n, ic_miss_req, e_req); end
      if (e_req) begin
        checks++; if (ic_miss_addr !== m_hpc) begin errors++; $display("FAIL rnd_miss_addr n=%0d got=%h exp=%h", n, ic_miss_addr, m_hpc); end
      end
      checks++; if (miss_count !== m_mc) begin errors++; $display("FAIL rnd_miss_count n=%0d got=%0d exp=%0d", n, miss_count, m_mc); end
      checks++; if (miss_cycles !== m_mcy) begin errors++; $display("FAIL rnd_miss_cycles n=%0d got=%0d exp=%0d", n, miss_cycles, m_mcy); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_back_to_back();
    test_miss();
    test_backpressure();
    test_clear_drain();
    test_partial();
    test_clear_missreq_and_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
